// File: rtl/unidade_mult_div.sv
// unidade_mult_div: iterative 32-bit multiply/divide unit holding HI/LO for the
// iZero MIPS datapath. A signed or unsigned MULT/DIV takes 33 busy cycles
// (32 CALC + 1 AJUSTE). MTHI/MTLO write HI/LO directly while idle.
module unidade_mult_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandoA,
    input  logic [31:0] operandoB,
    input  logic        escreveHI,
    input  logic        escreveLO,
    input  logic [31:0] dadosMT,
    input  logic        selHI,
    output logic [31:0] leituraHILO,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        divZero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        AJUSTE = 2'd2
    } estado_t;

    estado_t     estado_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] acc_q;      // multiply: upper product half; divide: partial remainder
    logic [31:0] mq_q;       // multiply: multiplier/lower product; divide: dividend/quotient
    logic [31:0] opb_q;      // multiply: multiplicand; divide: divisor
    logic [4:0]  cnt_q;
    logic [1:0]  op_q;
    logic        negq_q;     // negate product/quotient at the end
    logic        negr_q;     // negate remainder (dividend was negative)
    logic        busy_q, done_q, divz_q;

    // Operand preparation for the start cycle
    logic        a_neg, b_neg, div_zero_req;
    logic [31:0] abs_a, abs_b;

    // Iteration datapath
    logic [32:0] soma;
    logic [32:0] rem_sh;
    logic [31:0] dif;
    logic        ge;
    logic [31:0] acc_d, mq_d;

    // Result fix-up
    logic [63:0] prod, prod_fix;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] hi_d, lo_d;
    logic        com_sinal;

    // Absolute values and sign capture of the incoming operands
    always_comb begin
        a_neg        = ~op[0] & operandoA[31];
        b_neg        = ~op[0] & operandoB[31];
        abs_a        = a_neg ? (32'd0 - operandoA) : operandoA;
        abs_b        = b_neg ? (32'd0 - operandoB) : operandoB;
        div_zero_req = op[1] & (operandoB == '0);
    end

    // One shift-add (multiply) or restoring-subtract (divide) step per cycle
    always_comb begin
        soma   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : 33'd0);
        rem_sh = {acc_q, mq_q[31]};
        ge     = (rem_sh >= {1'b0, opb_q});
        // rem_sh - divisor < divisor whenever ge holds, so 32 bits suffice
        dif    = rem_sh[31:0] - opb_q;
        if (op_q[1]) begin
            acc_d = ge ? dif : rem_sh[31:0];
            mq_d  = {mq_q[30:0], ge};
        end else begin
            acc_d = soma[32:1];
            mq_d  = {soma[0], mq_q[31:1]};
        end
    end

    // Final sign correction and HI/LO placement
    always_comb begin
        com_sinal = ~op_q[0];
        prod      = {acc_q, mq_q};
        prod_fix  = (com_sinal & negq_q) ? (64'd0 - prod) : prod;
        quo_fix   = (com_sinal & negq_q) ? (32'd0 - mq_q) : mq_q;
        rem_fix   = (com_sinal & negr_q) ? (32'd0 - acc_q) : acc_q;
        if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
        end
    end

    // Control FSM with HI/LO and handshake registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            divz_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (start) begin
                        if (div_zero_req) begin
                            done_q <= 1'b1;
                            divz_q <= 1'b1;
                        end else begin
                            op_q     <= op;
                            acc_q    <= '0;
                            negq_q   <= a_neg ^ b_neg;
                            negr_q   <= a_neg;
                            cnt_q    <= 5'd31;
                            busy_q   <= 1'b1;
                            estado_q <= CALC;
                            if (op[1]) begin
                                mq_q  <= abs_a;
                                opb_q <= abs_b;
                            end else begin
                                mq_q  <= abs_b;
                                opb_q <= abs_a;
                            end
                        end
                    end else begin
                        if (escreveHI) hi_q <= dadosMT;
                        if (escreveLO) lo_q <= dadosMT;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == '0) estado_q <= AJUSTE;
                end
                AJUSTE: begin
                    hi_q     <= hi_d;
                    lo_q     <= lo_d;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    estado_q <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign leituraHILO = selHI ? hi_q : lo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign divZero     = divz_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: directed ops push expected HI/LO/divZero,
// a monitor pops and compares on every done pulse.
module tb_unidade_mult_div;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operandoA = '0;
    logic [31:0] operandoB = '0;
    logic        escreveHI = 1'b0;
    logic        escreveLO = 1'b0;
    logic [31:0] dadosMT = '0;
    logic        selHI = 1'b0;
    logic [31:0] leituraHILO, hi, lo;
    logic        busy, done, divZero;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_dones = 0;
    int          exp_dones = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    unidade_mult_div dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandoA(operandoA), .operandoB(operandoB),
        .escreveHI(escreveHI), .escreveLO(escreveLO), .dadosMT(dadosMT),
        .selHI(selHI), .leituraHILO(leituraHILO), .hi(hi), .lo(lo),
        .busy(busy), .done(done), .divZero(divZero)
    );

    always #5 clock = ~clock;

    task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nome, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    initial begin
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                n_dones++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_hi", hi, e.h);
                    check("result_lo", lo, e.l);
                    check("result_divZero", {31'd0, divZero}, {31'd0, e.dz});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clock);
        escreveHI = wh;
        escreveLO = wl;
        dadosMT   = d;
        @(negedge clock);
        escreveHI = 1'b0;
        escreveLO = 1'b0;
        if (wh) model_hi = d;
        if (wl) model_lo = d;
        check("mt_hi", hi, model_hi);
        check("mt_lo", lo, model_lo);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input logic disturb, input logic lo_write);
        exp_t e;
        int   bcnt;
        bit   seen;
        e.h = eh; e.l = el; e.dz = edz;
        @(negedge clock);
        sb.push_back(e);
        exp_dones++;
        start = 1'b1; op = o; operandoA = a; operandoB = b;
        if (lo_write) begin
            escreveLO = 1'b1;
            dadosMT   = 32'h5555_0000;
        end
        @(negedge clock);
        start = 1'b0;
        escreveLO = 1'b0;
        bcnt = 0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
            if (busy === 1'b1) bcnt++;
            if (busy === 1'b1 && bcnt == 10) begin
                check("calc_old_hi", hi, model_hi);
                check("calc_old_lo", lo, model_lo);
            end
            if (disturb && bcnt == 5) begin
                start = 1'b1; op = 2'b11; operandoB = '0;
                escreveHI = 1'b1; dadosMT = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
                escreveHI = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        escreveHI = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", bcnt, edz ? 32'd0 : 32'd33);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("divZero_one_cycle", {31'd0, divZero}, 32'd0);
        model_hi = eh;
        model_lo = el;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_divZero", {31'd0, divZero}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of CALC: abort with no done pulse
        @(negedge clock);
        start = 1'b1; op = 2'b00; operandoA = 32'hFFFF_FFFD; operandoB = 32'd7;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #2;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clock);

        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 1'b0, 1'b0, 1'b0);

        // Divide by zero with preloaded HI/LO
        mt(1'b1, 1'b1, 32'h0000_1234);
        do_op(2'b11, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0);

        // start/escreveHI pulsed while busy must be ignored
        do_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b1, 1'b0);

        // start with simultaneous escreveLO: op runs, LO write dropped
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 1'b1);

        // MFHI/MFLO read path
        mt(1'b1, 1'b0, 32'hAAAA_5555);
        selHI = 1'b1;
        #1;
        check("read_hi", leituraHILO, 32'hAAAA_5555);
        selHI = 1'b0;
        #1;
        check("read_lo", leituraHILO, model_lo);

        repeat (5) @(negedge clock);
        check("sb_empty", sb.size(), 32'd0);
        check("done_count", n_dones, exp_dones);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_mult_div.md
# unidade_mult_div

Iterative multi-cycle multiply/divide unit with architectural HI/LO registers for the iZero MIPS datapath. It consumes the two register-file read ports (RS/RT contents) for MULT, MULTU, DIV and DIVU, and holds the results in HI/LO. MFHI/MFLO results are sent back to the register-file write-data path, and MTHI/MTLO write HI/LO directly. A start/busy/done handshake lets the control unit stall the pipeline while an operation runs.

## Interface
- No parameters. Data width is fixed at 32 bits, and the iteration count is fixed at 32.
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin the operation selected by op; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- operandoA  in  32  RS contents: multiplicand or dividend
- operandoB  in  32  RT contents: multiplier or divisor
- escreveHI  in  1  MTHI: load dadosMT into HI
- escreveLO  in  1  MTLO: load dadosMT into LO
- dadosMT  in  32  data for MTHI/MTLO
- selHI  in  1  read select: 1 = HI, 0 = LO
- leituraHILO  out  32  combinational HI or LO per selHI (MFHI/MFLO data)
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in progress; the control unit stalls while high
- done  out  1  one-cycle pulse when HI/LO have been updated (or division by zero is flagged)
- divZero  out  1  one-cycle pulse, coincident with done, for DIV/DIVU with operandoB == 0

## Operation
- The FSM has three states: IDLE, CALC, AJUSTE.
- **Reset values:** state=IDLE, HI=LO=0, busy=0, done=0, divZero=0, internal counter and accumulators 0.
- **IDLE, start=1, division by zero (op DIV/DIVU with operandoB==0):**
  - Stay in IDLE; HI/LO are unchanged.
  - done=divZero=1 for the following cycle; busy stays 0.
- **IDLE, start=1, all other cases:**
  - Latch the operands. Signed ops latch absolute values and record the result sign(s); unsigned ops latch raw values.
  - counter=31, busy=1, go to CALC.
- **CALC, multiply:** shift-add over a 64-bit {acc, multiplier} register, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle.
  - The 33-bit partial remainder is compared against the 32-bit divisor.
- **CALC exit:** counter decrements each cycle. At counter==0 (32nd CALC cycle), go to AJUSTE.
- **AJUSTE, result placement:**
  - Multiply: HI=product[63:32], LO=product[31:0].
  - Divide: LO=quotient, HI=remainder.
- **AJUSTE, sign fix-up (signed ops only):**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
- **AJUSTE, handshake:** busy=0, done=1 for one cycle, return to IDLE.
- **Signed overflow case:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This falls out of the unsigned core; no special-casing.
- **MTHI/MTLO:** escreveHI/escreveLO load dadosMT in IDLE only. Both may assert in the same cycle.
- **Ignored inputs:** while busy=1, start, escreveHI and escreveLO are ignored. In IDLE, start takes priority: simultaneous escreveHI/escreveLO are ignored.
- **Reads:** leituraHILO/hi/lo always reflect the HI/LO registers. During CALC they show the old values; the new values appear only at AJUSTE.

## Timing
- start is sampled at rising edge N (IDLE). busy=1 from edge N.
- CALC occupies edges N+1..N+32. AJUSTE is edge N+33, which writes HI/LO, clears busy and sets done.
- Total: busy high for 33 cycles. The result is readable and done=1 in the cycle after edge N+33.
- A back-to-back start is accepted at edge N+34 at the earliest (first IDLE edge).
- Division by zero: done/divZero are high in the cycle after edge N; busy never asserts.
- MTHI/MTLO: value visible on hi/lo the cycle after the write edge.
- Reset mid-operation: immediate abort to IDLE. HI=LO=0, busy/done/divZero=0, with no done pulse.

## Test plan
- **Reset:** assert reset mid-CALC (edge N+10) -> busy=0, hi=lo=0, no done. The next start works normally.
- **MULT:**
  - MULT 0xFFFFFFFD (-3) x 7 -> after 33 busy cycles done pulses, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- **DIV:**
  - DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU 100 / 7 -> lo=14, hi=2.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Divide by zero:** DIVU 5 / 0 with hi=lo=0x1234 preloaded via MTHI/MTLO -> done=divZero=1 for one cycle after edge N, busy stays 0, hi=lo=0x1234.
- **Ignored inputs:**
  - start and escreveHI pulsed during busy -> ignored; the result matches the first op, and done fires exactly once.
  - start+escreveLO together in IDLE -> the op starts and the LO write is dropped.
- **Reads:** MTHI 0xAAAA5555 then selHI=1 -> leituraHILO=0xAAAA5555 the next cycle; selHI=0 -> LO value.
